// File: rtl/gmac_tx_chan_arbiter.sv
// -----------------------------------------------------------------------------
// gmac_tx_chan_arbiter
// Round-robin transmit arbiter in front of the GMAC TX byte interface.
// Grants one of CH_NUM request/confirm channels at a time, forwards its beats
// with one cycle of latency, aborts a grant whose SoF never arrives, truncates
// over-long frames with an error-qualified EoF, and inserts an inter-frame gap.
//
// Ports
//   clk125      in   clock, all logic on rising edge
//   rst_n       in   asynchronous active-low reset
//   ReqIn       in   per-channel frame request (level)
//   ValIn       in   per-channel beat valid
//   SoFIn       in   per-channel first-beat marker
//   EoFIn       in   per-channel last-beat marker
//   DataIn      in   channel i data in DataIn[i*DW +: DW]
//   MacBusy     in   blocks the IDLE->GRANT transition only
//   ReqConfirm  out  one-hot single-cycle grant pulse
//   ValOut      out  output beat valid (registered)
//   SoFOut      out  output first beat
//   EoFOut      out  output last beat
//   ErrOut      out  qualifies EoFOut: frame was truncated
//   DataOut     out  output data
//   ActiveCh    out  currently granted channel
//   Busy        out  arbiter not idle
//   AbortCnt    out  saturating count of start timeouts + truncations
// -----------------------------------------------------------------------------
module gmac_tx_chan_arbiter #(
   parameter int CH_NUM     = 4,
   parameter int DW         = 8,
   parameter int MAX_LEN    = 1518,
   parameter int START_TO   = 64,
   parameter int IFG_CYCLES = 12,
   localparam int CW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                 clk125,
   input  logic                 rst_n,
   input  logic [CH_NUM-1:0]    ReqIn,
   input  logic [CH_NUM-1:0]    ValIn,
   input  logic [CH_NUM-1:0]    SoFIn,
   input  logic [CH_NUM-1:0]    EoFIn,
   input  logic [CH_NUM*DW-1:0] DataIn,
   input  logic                 MacBusy,
   output logic [CH_NUM-1:0]    ReqConfirm,
   output logic                 ValOut,
   output logic                 SoFOut,
   output logic                 EoFOut,
   output logic                 ErrOut,
   output logic [DW-1:0]        DataOut,
   output logic [CW-1:0]        ActiveCh,
   output logic                 Busy,
   output logic [15:0]          AbortCnt
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = $clog2(START_TO + 1);
   localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_WAIT_SOF, S_XFER, S_DRAIN, S_IFG
   } state_t;

   // With no gap configured a finished frame returns straight to IDLE.
   localparam state_t S_AFTER = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t          r_state, w_state_nx;
   logic [CW-1:0]   r_sel, w_sel_nx;
   logic [CW-1:0]   r_ptr, w_ptr_nx;
   logic [CW-1:0]   w_pick, w_idx;
   logic [TW-1:0]   r_timer, w_timer_nx;
   logic [LW-1:0]   r_len, w_len_nx;
   logic [GW-1:0]   r_ifg, w_ifg_nx;
   logic [15:0]     r_abort, w_abort_nx;
   logic            w_abort_inc;
   logic            r_val_p1, r_sof_p1, r_eof_p1, r_err_p1;
   logic [DW-1:0]   r_data_p1;
   logic            w_val_nx, w_sof_nx, w_eof_nx, w_err_nx;
   logic [DW-1:0]   w_data_nx;
   logic            w_val, w_sof, w_eof;
   logic [DW-1:0]   w_din;

   // Only the granted channel is observed.
   assign w_val = ValIn[r_sel];
   assign w_sof = SoFIn[r_sel];
   assign w_eof = EoFIn[r_sel];

   always_comb begin
      w_din = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (r_sel == CW'(i)) w_din = DataIn[i*DW +: DW];
      end
   end

   // Scan from farthest to nearest so the requester closest after ptr wins;
   // ptr itself is visited first and therefore has the lowest priority.
   always_comb begin
      w_pick = r_ptr;
      w_idx  = r_ptr;
      for (int i = CH_NUM; i >= 1; i--) begin
         w_idx = CW'((int'(r_ptr) + i) % CH_NUM);
         if (ReqIn[w_idx]) w_pick = w_idx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_sel_nx    = r_sel;
      w_ptr_nx    = r_ptr;
      w_timer_nx  = r_timer;
      w_len_nx    = r_len;
      w_ifg_nx    = r_ifg;
      w_abort_inc = 1'b0;
      w_val_nx    = 1'b0;
      w_sof_nx    = 1'b0;
      w_eof_nx    = 1'b0;
      w_err_nx    = 1'b0;
      w_data_nx   = r_data_p1;
      case (r_state)
         S_IDLE: begin
            if (!MacBusy && (|ReqIn)) begin
               w_sel_nx   = w_pick;
               w_state_nx = S_GRANT;
            end
         end
         S_GRANT: begin
            w_timer_nx = '0;
            w_ptr_nx   = r_sel;
            w_state_nx = S_WAIT_SOF;
         end
         S_WAIT_SOF: begin
            if (w_val && w_sof) begin
               w_val_nx  = 1'b1;
               w_sof_nx  = 1'b1;
               w_data_nx = w_din;
               w_len_nx  = LW'(1);
               if (w_eof) begin
                  w_eof_nx   = 1'b1;
                  w_state_nx = S_AFTER;
               end else begin
                  w_state_nx = S_XFER;
               end
            end else if (r_timer == TW'(START_TO - 1)) begin
               w_abort_inc = 1'b1;
               w_state_nx  = S_AFTER;
            end else begin
               w_timer_nx = r_timer + 1'b1;
            end
         end
         S_XFER: begin
            if (w_val) begin
               w_val_nx  = 1'b1;
               w_data_nx = w_din;
               w_len_nx  = r_len + 1'b1;
               if (w_eof) begin
                  w_eof_nx   = 1'b1;
                  w_state_nx = S_AFTER;
               end else if (r_len == LW'(MAX_LEN - 1)) begin
                  // This beat reaches MAX_LEN: close the frame as truncated.
                  w_eof_nx    = 1'b1;
                  w_err_nx    = 1'b1;
                  w_abort_inc = 1'b1;
                  w_state_nx  = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_val && w_eof) w_state_nx = S_AFTER;
         end
         S_IFG: begin
            if (r_ifg == GW'(IFG_CYCLES - 1)) w_state_nx = S_IDLE;
            else                              w_ifg_nx   = r_ifg + 1'b1;
         end
         default: w_state_nx = S_IDLE;
      endcase
      if ((w_state_nx == S_IFG) && (r_state != S_IFG)) w_ifg_nx = '0;
      w_abort_nx = w_abort_inc ? sat_inc16(r_abort) : r_abort;
   end

   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // Output stage: one register between the granted channel and the MAC.
   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         r_sel     <= '0;
         r_ptr     <= CW'(CH_NUM - 1);
         r_timer   <= '0;
         r_len     <= '0;
         r_ifg     <= '0;
         r_abort   <= '0;
         r_val_p1  <= 1'b0;
         r_sof_p1  <= 1'b0;
         r_eof_p1  <= 1'b0;
         r_err_p1  <= 1'b0;
         r_data_p1 <= '0;
      end else begin
         r_sel     <= w_sel_nx;
         r_ptr     <= w_ptr_nx;
         r_timer   <= w_timer_nx;
         r_len     <= w_len_nx;
         r_ifg     <= w_ifg_nx;
         r_abort   <= w_abort_nx;
         r_val_p1  <= w_val_nx;
         r_sof_p1  <= w_sof_nx;
         r_eof_p1  <= w_eof_nx;
         r_err_p1  <= w_err_nx;
         r_data_p1 <= w_data_nx;
      end
   end

   assign ReqConfirm = (r_state == S_GRANT) ? (CH_NUM'(1) << r_sel) : '0;
   assign ValOut     = r_val_p1;
   assign SoFOut     = r_sof_p1;
   assign EoFOut     = r_eof_p1;
   assign ErrOut     = r_err_p1;
   assign DataOut    = r_data_p1;
   assign ActiveCh   = r_sel;
   assign Busy       = (r_state != S_IDLE);
   assign AbortCnt   = r_abort;

endmodule

// File: tb/tb_gmac_tx_chan_arbiter.sv
module tb_gmac_tx_chan_arbiter;

   localparam int NCH = 4;
   localparam int ML  = 64;
   localparam int STO = 64;
   localparam int IFG = 12;

   typedef struct packed {
      logic       sof;
      logic       eof;
      logic       err;
      logic [7:0] d;
   } beat_t;

   logic            clk125 = 1'b0;
   logic            rst_n  = 1'b0;
   logic [NCH-1:0]  ReqIn  = '0;
   logic [NCH-1:0]  ValIn  = '0;
   logic [NCH-1:0]  SoFIn  = '0;
   logic [NCH-1:0]  EoFIn  = '0;
   logic [NCH*8-1:0] DataIn = '0;
   logic            MacBusy = 1'b0;
   logic [NCH-1:0]  ReqConfirm;
   logic            ValOut, SoFOut, EoFOut, ErrOut, Busy;
   logic [7:0]      DataOut;
   logic [1:0]      ActiveCh;
   logic [15:0]     AbortCnt;

   gmac_tx_chan_arbiter #(
      .CH_NUM(NCH), .DW(8), .MAX_LEN(ML), .START_TO(STO), .IFG_CYCLES(IFG)
   ) dut (
      .clk125(clk125), .rst_n(rst_n), .ReqIn(ReqIn), .ValIn(ValIn),
      .SoFIn(SoFIn), .EoFIn(EoFIn), .DataIn(DataIn), .MacBusy(MacBusy),
      .ReqConfirm(ReqConfirm), .ValOut(ValOut), .SoFOut(SoFOut),
      .EoFOut(EoFOut), .ErrOut(ErrOut), .DataOut(DataOut),
      .ActiveCh(ActiveCh), .Busy(Busy), .AbortCnt(AbortCnt)
   );

   always #4 clk125 = ~clk125;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_eof_cyc = -1;
   int         exp_abort = 0;
   beat_t      exp_q[$];
   logic [1:0] gnt_q[$];

   always @(posedge clk125) cyc <= cyc + 1;

   // Scoreboard monitor: grants and output beats are popped as they appear.
   always @(negedge clk125) begin
      if (rst_n) begin
         if (ReqConfirm != '0) begin
            n_checks++;
            if (gnt_q.size() == 0) begin
               n_fail++;
               $display("FAIL grant_order: unexpected ReqConfirm=%b, none required", ReqConfirm);
            end else begin
               logic [1:0] e;
               e = gnt_q.pop_front();
               if (ReqConfirm != (4'b0001 << e)) begin
                  n_fail++;
                  $display("FAIL grant_order: ReqConfirm=%b, required %b", ReqConfirm, 4'b0001 << e);
               end
            end
            if (last_eof_cyc >= 0) begin
               n_checks++;
               if (cyc - last_eof_cyc - 1 < IFG) begin
                  n_fail++;
                  $display("FAIL ifg_gap: %0d idle cycles, required >= %0d", cyc - last_eof_cyc - 1, IFG);
               end
            end
         end
         if (ValOut) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL beat: unexpected ValOut data=%h sof=%b eof=%b err=%b", DataOut, SoFOut, EoFOut, ErrOut);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               if ({SoFOut, EoFOut, ErrOut, DataOut} != b) begin
                  n_fail++;
                  $display("FAIL beat: got sof=%b eof=%b err=%b data=%h, required sof=%b eof=%b err=%b data=%h",
                           SoFOut, EoFOut, ErrOut, DataOut, b.sof, b.eof, b.err, b.d);
               end
            end
            if (EoFOut) last_eof_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic drive_beat(input logic [1:0] ch, input logic s, input logic e, input logic [7:0] d);
      ValIn[ch] = 1'b1;
      SoFIn[ch] = s;
      EoFIn[ch] = e;
      DataIn[{ch, 3'b000} +: 8] = d;
   endtask

   task automatic drive_idle(input logic [1:0] ch);
      ValIn[ch] = 1'b0;
      SoFIn[ch] = 1'b0;
      EoFIn[ch] = 1'b0;
      DataIn[{ch, 3'b000} +: 8] = 8'h00;
   endtask

   // Returns at the negedge where ReqConfirm[ch] is seen; releases ReqIn[ch].
   task automatic wait_grant(input logic [1:0] ch, input int budget);
      bit seen = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk125);
         if (ReqConfirm[ch]) begin
            seen = 1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL grant_wait: no ReqConfirm for ch%0d within %0d cycles", ch, budget);
      end else begin
         check("active_ch", 64'(ActiveCh), 64'(ch));
      end
      ReqIn[ch] = 1'b0;
   endtask

   // Sends junk non-SoF beats, then an n-beat frame; every gap_every-th cycle
   // is left idle. Beats past ML are dropped, beat ML-1 closes with error.
   task automatic send_frame(input logic [1:0] ch, input int n, input logic [7:0] base,
                             input int junk, input int gap_every);
      bit    prev_exp = 0;
      int    i = 0;
      int    c = 0;
      beat_t b;
      while (i < n) begin
         @(posedge clk125); #1;
         check("lag_valout", 64'(ValOut), 64'(prev_exp));
         drive_idle(ch);
         prev_exp = 0;
         if (c < junk) begin
            drive_beat(ch, 1'b0, 1'b0, 8'hEE);
         end else if (gap_every != 0 && (c % gap_every) == gap_every - 1) begin
            prev_exp = 0;
         end else begin
            drive_beat(ch, i == 0, i == n - 1, base + 8'(i));
            if (i < ML) begin
               b.sof = (i == 0);
               b.eof = (i == n - 1) || (i == ML - 1);
               b.err = (i == ML - 1) && (i != n - 1);
               b.d   = base + 8'(i);
               exp_q.push_back(b);
               prev_exp = 1;
            end
            i++;
         end
         c++;
      end
      if (n > ML) exp_abort++;
      @(posedge clk125); #1;
      check("lag_valout", 64'(ValOut), 64'(prev_exp));
      drive_idle(ch);
   endtask

   initial begin
      int c1;
      #5;
      check("reset_outputs",
            64'({ValOut, SoFOut, EoFOut, ErrOut, DataOut, Busy, ReqConfirm, ActiveCh, AbortCnt}), 64'd0);
      repeat (3) @(negedge clk125);
      rst_n = 1'b1;
      @(negedge clk125);
      check("idle_busy", 64'(Busy), 64'd0);

      // All four request: round robin 0,1,2,3 then 0 again, gapped frames.
      ReqIn = 4'hF;
      for (int k = 0; k < 5; k++) gnt_q.push_back(2'(k % 4));
      for (int k = 0; k < 5; k++) begin
         wait_grant(2'(k % 4), 100);
         send_frame(2'(k % 4), 10, 8'(k * 16), 0, 4);
         if (k == 0) ReqIn[0] = 1'b1;
      end

      // ch2 alone, 64 beats 0x00..0x3F: exactly ML beats ends normally.
      @(negedge clk125);
      ReqIn[2] = 1'b1;
      gnt_q.push_back(2'd2);
      wait_grant(2'd2, 100);
      send_frame(2'd2, 64, 8'h00, 0, 0);

      // ch1 granted, never sends SoF; ch2 waits behind it.
      @(negedge clk125);
      ReqIn = 4'b0110;
      gnt_q.push_back(2'd1);
      gnt_q.push_back(2'd2);
      wait_grant(2'd1, 100);
      c1 = cyc;
      wait_grant(2'd2, 200);
      check("timeout_regrant_cycles", 64'(cyc - c1), 64'(STO + IFG + 2));
      exp_abort++;
      check("abort_after_timeout", 64'(AbortCnt), 64'(exp_abort));
      send_frame(2'd2, 6, 8'h50, 2, 0);

      // ch0 sends 80 beats: truncated at 64 with error, rest drained.
      @(negedge clk125);
      ReqIn[0] = 1'b1;
      gnt_q.push_back(2'd0);
      wait_grant(2'd0, 100);
      send_frame(2'd0, 80, 8'h00, 0, 0);
      check("abort_after_trunc", 64'(AbortCnt), 64'(exp_abort));

      // Single-beat frame on ch3.
      @(negedge clk125);
      ReqIn[3] = 1'b1;
      gnt_q.push_back(2'd3);
      wait_grant(2'd3, 100);
      send_frame(2'd3, 1, 8'hA5, 0, 0);

      // MacBusy holds off the grant; once granted, MacBusy mid-frame is ignored.
      @(negedge clk125);
      MacBusy = 1'b1;
      ReqIn[1] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk125);
         check("macbusy_no_grant", 64'(ReqConfirm), 64'd0);
      end
      MacBusy = 1'b0;
      gnt_q.push_back(2'd1);
      wait_grant(2'd1, 10);
      MacBusy = 1'b1;
      send_frame(2'd1, 5, 8'h60, 0, 2);
      MacBusy = 1'b0;
      check("abort_unchanged", 64'(AbortCnt), 64'(exp_abort));

      // Async reset during beat 5 of a ch2 frame.
      @(negedge clk125);
      ReqIn[2] = 1'b1;
      gnt_q.push_back(2'd2);
      wait_grant(2'd2, 100);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk125); #1;
         drive_beat(2'd2, i == 0, 1'b0, 8'h70 + 8'(i));
         if (i < 5) exp_q.push_back({i == 0, 1'b0, 1'b0, 8'h70 + 8'(i)});
      end
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            64'({ValOut, SoFOut, EoFOut, ErrOut, DataOut, Busy, ReqConfirm, ActiveCh, AbortCnt}), 64'd0);
      drive_idle(2'd2);
      exp_q.delete();
      gnt_q.delete();
      exp_abort = 0;
      repeat (3) @(negedge clk125);
      rst_n = 1'b1;
      @(negedge clk125);
      check("post_reset_busy", 64'(Busy), 64'd0);
      ReqIn = 4'hF;
      gnt_q.push_back(2'd0);
      wait_grant(2'd0, 20);
      ReqIn = 4'h0;
      send_frame(2'd0, 3, 8'h30, 0, 0);

      repeat (20) @(negedge clk125);
      check("beats_outstanding", 64'(exp_q.size()), 64'd0);
      check("grants_outstanding", 64'(gnt_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
